bcd_to_binary_seq: RTL

- Multi-digit, parametrised BCD-to-binary converter; successor to the single-byte combinational converter.
- Converts a DIGITS-digit packed BCD word with an iterative multiply-by-10 accumulate, one digit per clock, MSD first.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths (display/keypad front-ends, serial number parsers).
- Optional invalid-digit detection.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_mac.sv | 31 +++
 rtl/bcd_to_binary_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential BCD-to-binary converter.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding, BCD digit constants and the minimum result-width function.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } bcd_state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_DIGIT_MAX = 9;

    // Smallest w with 2^w > 10^digits - 1, i.e. every legal BCD word fits.
    function automatic int bcd_bin_width(input int digits);
        longint unsigned pow10;
        int              w;
        pow10 = 64'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        w = 1;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) < pow10) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One accumulate step: acc*10 + digit, plus a flag for a nibble above 9 (BCD_TO_BINARY_ERR_EN only).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic [OUT_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]       acc_next,
    output logic                   digit_bad
);

    logic [OUT_W+BCD_DIGIT_W-1:0] acc_w;
    logic [OUT_W+BCD_DIGIT_W-1:0] sum_w;
    logic [BCD_DIGIT_W-1:0]       unused_sum_hi;

    // x*10 as (x<<3)+(x<<1); computed wide, result taken modulo 2^OUT_W.
    assign acc_w         = {{BCD_DIGIT_W{1'b0}}, acc};
    assign sum_w         = (acc_w << 3) + (acc_w << 1) + {{OUT_W{1'b0}}, digit};
    assign acc_next      = sum_w[OUT_W-1:0];
    assign unused_sum_hi = sum_w[OUT_W+BCD_DIGIT_W-1:OUT_W];

`ifdef BCD_TO_BINARY_ERR_EN
    assign digit_bad = (digit > BCD_DIGIT_W'(BCD_DIGIT_MAX));
`else
    assign digit_bad = 1'b0;
`endif

endmodule

// File: rtl/bcd_to_binary_seq.sv
// DIGITS-digit packed BCD to binary, MSD first, one digit per clock; BCD_TO_BINARY_ERR_EN adds invalid-digit err.
// Latency: out_valid rises DIGITS cycles after the accept edge; one word per DIGITS+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds bin_out/err frozen until out_ready.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              bin_out,
    output logic                          err,
    output logic                          busy
);

    localparam int                IN_W     = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIGITS - 1);

    if (DIGITS < 1 || OUT_W < bcd_bin_width(DIGITS)) begin : g_bad_params
        $error("bcd_to_binary_seq: OUT_W too narrow for DIGITS");
    end

    bcd_state_t        state;
    bcd_state_t        state_nxt;
    logic [IN_W-1:0]   shift_q;
    logic [OUT_W-1:0]  acc_q;
    logic [OUT_W-1:0]  acc_nxt;
    logic [OUT_W-1:0]  bin_q;
    logic [OUT_W-1:0]  result;
    logic [CNT_W-1:0]  cnt_q;
    logic              digit_bad;
    logic              accept;
    logic              last_digit;

    bcd_digit_mac #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc       (acc_q),
        .digit     (shift_q[IN_W-1 -: BCD_DIGIT_W]),
        .acc_next  (acc_nxt),
        .digit_bad (digit_bad)
    );

    assign accept     = in_valid && in_ready;
    assign last_digit = (state == CONV) && (cnt_q == CNT_LAST);
    assign bin_out    = bin_q;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shift_q <= bcd_in;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state == CONV) begin
                shift_q <= shift_q << BCD_DIGIT_W;
                acc_q   <= acc_nxt;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_digit) bin_q <= result;
            end
        end
    end

`ifdef BCD_TO_BINARY_ERR_EN
    logic err_acc_q;
    logic err_q;
    logic err_final;

    // Includes the digit being consumed this cycle so the last digit counts too.
    assign err_final = err_acc_q | digit_bad;
    assign result    = err_final ? '0 : acc_nxt;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            err_acc_q <= 1'b0;
        end else if (state == CONV) begin
            err_acc_q <= err_final;
            if (last_digit) err_q <= err_final;
        end
    end
`else
    logic unused_digit_bad;

    assign unused_digit_bad = digit_bad;
    assign result           = acc_nxt;
    assign err              = 1'b0;
`endif

endmodule
